adjust_ctrl: RTL and testbench
==============================

# adjust_ctrl

Time/alarm adjust controller for the digital alarm clock. Takes three raw pushbuttons, synchronizes, debounces and edge-detects them, and runs a mode state machine. The outputs are the command side of the up/down modulo counters: one-cycle enable pulses, a direction bit, and a seconds-load strobe. It sits between the board buttons and the clock/alarm hour and minute counters.

## Interface
- DEB_CYCLES, 500000: cycles a synchronized button must stay stable before its debounced value updates.
- REPEAT_DELAY, 25000000: cycles from a press to the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 10000000: cycles between auto-repeat pulses. Used only with AUTO_REPEAT_EN.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw mode button, active-high, asynchronous.
- btn_up  in  1  raw increment button, active-high, asynchronous.
- btn_down  in  1  raw decrement button, active-high, asynchronous.
- cnt_en  out  4  one-hot, one-cycle enable pulses:
  - [0] clock minutes
  - [1] clock hours
  - [2] alarm minutes
  - [3] alarm hours
- cnt_upDown  out  1  counter direction: 0 = up, 1 = down. Valid whenever any cnt_en bit is high.
- sec_ld  out  1  one-cycle strobe that loads 0 into the seconds counter.
- run_en  out  1  timekeeping enable; high only in RUN.
- mode  out  3  current state encoding, for the LEDs.

## Operation
- Input conditioning, per button:
  - 2-FF synchronizer.
  - Stability counter: the debounced value takes the synchronized value after DEB_CYCLES consecutive equal samples. Any change restarts the counter.
  - Press pulse = one-cycle rising edge of the debounced value.
- States and mode encoding: RUN=0, ADJ_CLK_HR=1, ADJ_CLK_MIN=2, ADJ_ALM_HR=3, ADJ_ALM_MIN=4. Codes 5–7 are unreachable and recover to RUN on the next clock.
- A mode press advances RUN→ADJ_CLK_HR→ADJ_CLK_MIN→ADJ_ALM_HR→ADJ_ALM_MIN→RUN.
- Leaving ADJ_CLK_MIN asserts sec_ld for exactly one cycle, so seconds restart at 0 after a clock edit.
- In an ADJ state:
  - An up press emits cnt_en[target]=1 with cnt_upDown=0.
  - A down press emits cnt_en[target]=1 with cnt_upDown=1.
  - Targets: ADJ_CLK_MIN→bit0, ADJ_CLK_HR→bit1, ADJ_ALM_MIN→bit2, ADJ_ALM_HR→bit3.
- In RUN, up and down presses are ignored.
- Simultaneous events:
  - Up and down pulses in the same cycle: both dropped.
  - Mode pulse in the same cycle as up or down: the state advances and up/down are dropped.
- cnt_upDown holds its last value between pulses.
- At most one cnt_en bit is ever high.
- Wrap-around of hours and minutes belongs to the counters; this block never inspects counter values.

## Timing
- Reset values:
  - state RUN, mode=0, run_en=1
  - cnt_en=0, cnt_upDown=0, sec_ld=0
  - debounced values 0, all counters 0
- Press latency: a raw edge held stable produces its press pulse 2 + DEB_CYCLES + 1 cycles later. All outputs are registered: cnt_en, cnt_upDown, sec_ld and the new state/mode appear one cycle after the press pulse.
- run_en changes in the same cycle as mode.
- Reset mid-operation: any in-flight pulse is cancelled, debounce progress is lost, and the state returns to RUN immediately (asynchronously).
- Bounces shorter than DEB_CYCLES produce no pulse.
- Release produces no output.

## Configuration
- AUTO_REPEAT_EN defined:
  - While up or down (exactly one) stays debounced-high in an ADJ state, a repeat counter starts at the press pulse.
  - The first extra pulse comes REPEAT_DELAY cycles after the press pulse; further pulses follow every REPEAT_PERIOD cycles, each with the same target and direction.
  - The repeat counter clears on release, on the other direction button going high, on a mode press, or on reset.
- AUTO_REPEAT_EN undefined: exactly one pulse per press, no repeat logic is synthesized, and REPEAT_DELAY and REPEAT_PERIOD are unused.

## Test plan
Unless a line says otherwise, use DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=5.

- Reset: hold rst=0 for 5 cycles, then release. Outputs must read mode=0, run_en=1, cnt_en=0, sec_ld=0; no pulses occur while the buttons stay 0.
- Debounce: toggle btn_up every 2 cycles for 20 cycles, then hold it high in ADJ_CLK_HR. Exactly one cnt_en=4'b0010 pulse with cnt_upDown=0 must occur, 8 cycles after the stable edge.
- Mode walk: press mode 5 times. mode must step 1,2,3,4,0; run_en must be 0 for states 1–4; sec_ld must pulse once, on the 2→3 transition.
- Direction and target: in ADJ_ALM_MIN, press down once. cnt_en=4'b0100 and cnt_upDown=1 must both be present in the same single cycle.
- Simultaneous: press up and down in the same cycle while in ADJ_CLK_MIN, and separately press mode together with up. The first gives no cnt_en pulse; the second gives no cnt_en pulse and mode advances to 3.
- Auto-repeat, with AUTO_REPEAT_EN defined: hold up for 40 cycles after its press pulse in ADJ_CLK_HR. Pulses must occur at offsets +1, +21, +26, +31, +36. Without the macro, only the +1 pulse occurs.

Source files
------------

// File: rtl/adjust_ctrl.sv
// adjust_ctrl: conditions the mode/up/down pushbuttons and runs the time/alarm adjust mode FSM.
// Define AUTO_REPEAT_EN to add hold-to-repeat on the up/down buttons.
module adjust_ctrl #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] cnt_en,
    output logic       cnt_upDown,
    output logic       sec_ld,
    output logic       run_en,
    output logic [2:0] mode
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        ADJ_CLK_HR  = 3'd1,
        ADJ_CLK_MIN = 3'd2,
        ADJ_ALM_HR  = 3'd3,
        ADJ_ALM_MIN = 3'd4
    } state_t;

    if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_check
        $error("adjust_ctrl: cycle parameters must be at least 1");
    end

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt_en_nxt;
    logic [3:0]       tgt_c;
    logic             dir_nxt;
    logic             sec_ld_nxt;

    // Button bit order: [0] mode, [1] up, [2] down
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       deb;
    logic [2:0]       deb_q;
    logic [2:0]       press;
    logic [DEB_W-1:0] deb_cnt [3];

    logic             mode_p;
    logic             up_p;
    logic             dn_p;
    logic             up_evt;
    logic             dn_evt;

    assign raw    = {btn_down, btn_up, btn_mode};
    assign mode_p = press[0];
    assign up_p   = press[1];
    assign dn_p   = press[2];

    // Synchronize, debounce (counter restarts whenever the sample matches the held value), detect rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic             rep_act;
    logic             rep_first;
    logic             rep_dir;
    logic [REP_W-1:0] rep_cnt;
    logic             rep_start_c;
    logic             rep_clr_c;
    logic             rep_fire_c;

    assign rep_start_c = (state != RUN) && !mode_p && (up_p ^ dn_p);
    assign rep_clr_c   = mode_p || (state == RUN) ||
                         (rep_dir ? (!deb[2] || deb[1]) : (!deb[1] || deb[2]));
    assign rep_fire_c  = rep_act && !rep_clr_c &&
                         (rep_cnt == (rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1)));

    // Repeat timer: armed by an accepted press, killed by release, opposite button or mode press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_act   <= 1'b0;
            rep_first <= 1'b0;
            rep_dir   <= 1'b0;
            rep_cnt   <= '0;
        end else if (rep_start_c) begin
            rep_act   <= 1'b1;
            rep_first <= 1'b1;
            rep_dir   <= dn_p;
            rep_cnt   <= '0;
        end else if (!rep_act || rep_clr_c) begin
            rep_act <= 1'b0;
            rep_cnt <= '0;
        end else if (rep_fire_c) begin
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end

    assign up_evt = up_p | (rep_fire_c & ~rep_dir);
    assign dn_evt = dn_p | (rep_fire_c & rep_dir);
`else
    assign up_evt = up_p;
    assign dn_evt = dn_p;
`endif

    // Next state and next registered outputs
    always_comb begin
        state_nxt  = state;
        cnt_en_nxt = '0;
        dir_nxt    = cnt_upDown;
        sec_ld_nxt = 1'b0;
        tgt_c      = '0;
        case (state)
            RUN: begin
                if (mode_p) state_nxt = ADJ_CLK_HR;
            end
            ADJ_CLK_HR: begin
                tgt_c = 4'b0010;
                if (mode_p) state_nxt = ADJ_CLK_MIN;
            end
            ADJ_CLK_MIN: begin
                tgt_c = 4'b0001;
                if (mode_p) begin
                    state_nxt  = ADJ_ALM_HR;
                    sec_ld_nxt = 1'b1;
                end
            end
            ADJ_ALM_HR: begin
                tgt_c = 4'b1000;
                if (mode_p) state_nxt = ADJ_ALM_MIN;
            end
            ADJ_ALM_MIN: begin
                tgt_c = 4'b0100;
                if (mode_p) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        // tgt_c is zero in RUN and in illegal codes, so no pulse can escape there
        if (!mode_p && (up_evt ^ dn_evt) && (tgt_c != 4'b0000)) begin
            cnt_en_nxt = tgt_c;
            dir_nxt    = dn_evt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            cnt_en     <= '0;
            cnt_upDown <= 1'b0;
            sec_ld     <= 1'b0;
            run_en     <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt_en     <= cnt_en_nxt;
            cnt_upDown <= dir_nxt;
            sec_ld     <= sec_ld_nxt;
            run_en     <= (state_nxt == RUN);
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_adjust_ctrl.sv
// tb_adjust_ctrl: directed and randomized stimulus for adjust_ctrl, checked every cycle
// against a cycle-timed behavioural model of the button-to-command rules.
module tb_adjust_ctrl;

    localparam int DEB  = 4;
    localparam int RDLY = 20;
    localparam int RPER = 5;
    localparam int WIN  = DEB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] cnt_en;
    logic       cnt_upDown;
    logic       sec_ld;
    logic       run_en;
    logic [2:0] mode;

    always #5 clk = ~clk;

    adjust_ctrl #(
        .DEB_CYCLES   (DEB),
        .REPEAT_DELAY (RDLY),
        .REPEAT_PERIOD(RPER)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_mode  (btn_mode),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .cnt_en    (cnt_en),
        .cnt_upDown(cnt_upDown),
        .sec_ld    (sec_ld),
        .run_en    (run_en),
        .mode      (mode)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit rst_lvl = 1'b0;

    // Model: raw sample history per button (index 0 = newest), debounced level, delayed rise flags
    bit         hist [3][WIN];
    bit         md [3];
    bit         r1 [3];
    bit         r2 [3];
    int         ms;
    logic [3:0] e_en;
    bit         e_dir;
    bit         e_sec;
    bit         rep_on;
    bit         rep_dn;
    int         rep_k0;

    // Observation bookkeeping for directed checks
    int         n_en;
    int         n_sec;
    int         sec_mode;
    logic [3:0] last_en;
    logic       last_dir;
    int         last_pc;
    int         pulse_q[$];

    function automatic int tgt_bit(input int s);
        case (s)
            1:       return 1;
            2:       return 0;
            3:       return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < WIN; j++) hist[b][j] = 1'b0;
            md[b] = 1'b0;
            r1[b] = 1'b0;
            r2[b] = 1'b0;
        end
        ms     = 0;
        e_en   = '0;
        e_dir  = 1'b0;
        e_sec  = 1'b0;
        rep_on = 1'b0;
        rep_dn = 1'b0;
        rep_k0 = 0;
    endtask

    task automatic model_edge(input bit m, input bit u, input bit d);
        bit pm, pu, pd, fu, fd, ue, de, all_diff, hold_ok;
        bit nr [3];
        bit rw [3];
        pm = r2[0];
        pu = r2[1];
        pd = r2[2];
        fu = 1'b0;
        fd = 1'b0;
`ifdef AUTO_REPEAT_EN
        if (ms != 0 && !pm && (pu ^ pd)) begin
            rep_on = 1'b1;
            rep_k0 = cyc;
            rep_dn = pd;
        end else if (rep_on) begin
            hold_ok = rep_dn ? (md[2] && !md[1]) : (md[1] && !md[2]);
            if (pm || ms == 0 || !hold_ok) rep_on = 1'b0;
            else if (cyc - rep_k0 >= RDLY && (cyc - rep_k0 - RDLY) % RPER == 0) begin
                fu = !rep_dn;
                fd = rep_dn;
            end
        end
`else
        hold_ok = 1'b0;
`endif
        ue    = pu | fu;
        de    = pd | fd;
        e_en  = '0;
        e_sec = 1'b0;
        if (pm) begin
            e_sec = (ms == 2);
            ms    = (ms + 1) % 5;
        end else if (ms != 0 && (ue ^ de)) begin
            e_en  = 4'b0001 << tgt_bit(ms);
            e_dir = de;
        end
        // Debounced level flips once the last DEB synchronized samples all disagree with it
        rw[0] = m;
        rw[1] = u;
        rw[2] = d;
        for (int b = 0; b < 3; b++) begin
            for (int j = WIN - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = rw[b];
            all_diff = 1'b1;
            for (int j = 2; j <= DEB + 1; j++) if (hist[b][j] == md[b]) all_diff = 1'b0;
            nr[b] = all_diff && !md[b];
            if (all_diff) md[b] = !md[b];
        end
        r2 = r1;
        r1 = nr;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("cnt_en",     32'(cnt_en),     32'(e_en));
        chk("cnt_upDown", 32'(cnt_upDown), 32'(e_dir));
        chk("sec_ld",     32'(sec_ld),     32'(e_sec));
        chk("run_en",     32'(run_en),     32'(ms == 0));
        chk("mode",       32'(mode),       32'(ms));
    endtask

    task automatic tick(input bit m, input bit u, input bit d);
        @(negedge clk);
        rst      = rst_lvl;
        btn_mode = m;
        btn_up   = u;
        btn_down = d;
        @(posedge clk);
        cyc++;
        if (rst) model_edge(m, u, d);
        #1;
        check_all();
        if (cnt_en != 4'b0000) begin
            n_en++;
            last_en  = cnt_en;
            last_dir = cnt_upDown;
            last_pc  = cyc;
            pulse_q.push_back(cyc);
        end
        if (sec_ld) begin
            n_sec++;
            sec_mode = int'(mode);
        end
    endtask

    task automatic hold(input bit m, input bit u, input bit d, input int n);
        for (int i = 0; i < n; i++) tick(m, u, d);
    endtask

    task automatic press_mode();
        hold(1'b1, 1'b0, 1'b0, 8);
        hold(1'b0, 1'b0, 1'b0, 8);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst     = 1'b0;
        rst_lvl = 1'b0;
        #1;
        model_reset();
        check_all();
        hold(btn_mode, btn_up, btn_down, 3);
        rst_lvl = 1'b1;
    endtask

    initial begin
        int walk_exp [5] = '{1, 2, 3, 4, 0};
        int exp_off[$];
        int drive_cyc;
        int t_end;
        bit did_rst;

        model_reset();
        #1 rst = 1'b0;

        // Reset held for 5 cycles, then idle buttons must stay silent
        hold(1'b0, 1'b0, 1'b0, 5);
        rst_lvl = 1'b1;
        n_en = 0;
        n_sec = 0;
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("idle_pulses", 32'(n_en + n_sec), 32'd0);

        // Mode walk through all five states
        n_sec = 0;
        sec_mode = -1;
        for (int i = 0; i < 5; i++) begin
            press_mode();
            chk("walk_mode", 32'(mode), 32'(walk_exp[i]));
            chk("walk_run_en", 32'(run_en), 32'(walk_exp[i] == 0));
        end
        chk("walk_sec_ld_count", 32'(n_sec), 32'd1);
        chk("walk_sec_ld_mode", 32'(sec_mode), 32'd3);

        // Bouncing up button in ADJ_CLK_HR, then a stable press
        press_mode();
        n_en = 0;
        for (int i = 0; i < 10; i++) hold(1'b0, (i % 2) == 0, 1'b0, 2);
        drive_cyc = cyc;
        hold(1'b0, 1'b1, 1'b0, 15);
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("deb_count", 32'(n_en), 32'd1);
        chk("deb_target", 32'(last_en), 32'b0010);
        chk("deb_dir", 32'(last_dir), 32'd0);
        chk("deb_latency", 32'(last_pc - drive_cyc), 32'd8);

        // ADJ_CLK_MIN: up+down together are dropped
        press_mode();
        n_en = 0;
        hold(1'b0, 1'b1, 1'b1, 10);
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("updown_dropped", 32'(n_en), 32'd0);

        // Mode together with up: state advances, no count pulse
        n_en = 0;
        hold(1'b1, 1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("modeup_dropped", 32'(n_en), 32'd0);
        chk("modeup_mode", 32'(mode), 32'd3);

        // ADJ_ALM_MIN: down press targets alarm minutes, downward
        press_mode();
        n_en = 0;
        hold(1'b0, 1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("alm_min_count", 32'(n_en), 32'd1);
        chk("alm_min_target", 32'(last_en), 32'b0100);
        chk("alm_min_dir", 32'(last_dir), 32'd1);

        // RUN ignores up
        press_mode();
        n_en = 0;
        hold(1'b0, 1'b1, 1'b0, 10);
        hold(1'b0, 1'b0, 1'b0, 10);
        chk("run_ignores_up", 32'(n_en), 32'd0);

        // Long hold in ADJ_CLK_HR: debounced high for 40 cycles after the press pulse
        press_mode();
        pulse_q.delete();
        drive_cyc = cyc;
        hold(1'b0, 1'b1, 1'b0, 41);
        hold(1'b0, 1'b0, 1'b0, 15);
`ifdef AUTO_REPEAT_EN
        exp_off = '{1, 21, 26, 31, 36};
`else
        exp_off = '{1};
`endif
        chk("repeat_count", 32'(pulse_q.size()), 32'(exp_off.size()));
        for (int i = 0; i < exp_off.size(); i++) begin
            if (i < pulse_q.size()) chk("repeat_offset", 32'(pulse_q[i] - (drive_cyc + 7)), 32'(exp_off[i]));
            else chk("repeat_offset_missing", 32'hFFFF_FFFF, 32'(exp_off[i]));
        end

        // Random button activity, with one asynchronous reset partway through
        t_end = cyc + 900;
        did_rst = 1'b0;
        while (cyc < t_end) begin
            bit m, u, d;
            int len;
            m = ($urandom_range(0, 3) == 0);
            u = ($urandom_range(0, 2) == 0);
            d = ($urandom_range(0, 2) == 0);
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(25, 45)) : int'($urandom_range(1, 12));
            hold(m, u, d, len);
            if (!did_rst && cyc > t_end - 450) begin
                did_rst = 1'b1;
                mid_reset();
            end
        end
        hold(1'b0, 1'b0, 1'b0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
